// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage-side signal bundle for the Y86-64 pipeline control unit
//
// Purpose: groups the hazard inputs taken from the stage registers/outputs
// and the control, status and counter outputs returned to the pipeline.
// Ports (signals):
//   D_icode, d_srcA, d_srcB        decode register icode / decode sources
//   E_icode, E_dstM, e_cnd         execute register icode, load dest, condition
//   M_icode, m_stat                memory register icode, memory-stage status
//   W_icode, W_stat                writeback register icode and status
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
//   cpu_stat, halted               processor status
//   cycle_count, instr_count, lu_count, mp_count  performance counters
// Modports: master = pipeline stages, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic [2:0]       m_stat;
  logic [3:0]       W_icode;
  logic [2:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic [2:0]       cpu_stat;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] lu_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_icode, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           cpu_stat, halted, cycle_count, instr_count, lu_count, mp_count
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_icode, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           cpu_stat, halted, cycle_count, instr_count, lu_count, mp_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline stall/bubble control, status FSM and perf counters
//
// Purpose: combinational stall/bubble/set_cc generation for the F/D/E/M/W
// pipeline registers, RUN/STOPPED processor status machine and saturating
// performance counters.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_if.slave: hazard inputs in, controls/status/counters out
module pipe_ctrl #(
  parameter int         CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN,
    ST_STOPPED
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cpu_stat;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_lu_count;
  logic [CNT_W-1:0] r_mp_count;

  logic w_run;
  logic w_load_use;
  logic w_ret_pend;
  logic w_mispred;
  logic w_m_ok;
  logic w_w_ok;
  logic w_retire;

  // Hazard detection. A load (mrmovq/popq) in E whose destination feeds a
  // decode source must hold F/D for a cycle and inject a bubble into E.
  assign w_run      = (r_state == ST_RUN);
  assign w_load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                      (bus.E_dstM != RNONE) &&
                      ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign w_ret_pend = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                      (bus.M_icode == I_RET);
  assign w_mispred  = (bus.E_icode == I_JXX) && !bus.e_cnd;
  assign w_m_ok     = (bus.m_stat == STAT_AOK);
  assign w_w_ok     = (bus.W_stat == STAT_AOK);
  assign w_retire   = w_w_ok && (bus.W_icode != I_NOP);

  // In STOPPED the pipeline is frozen: front end and writeback held, no
  // bubbles, no condition-code writes.
  always_comb begin
    bus.F_stall  = 1'b1;
    bus.D_stall  = 1'b1;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b1;
    bus.set_cc   = 1'b0;
    if (w_run) begin
      bus.F_stall  = w_load_use | w_ret_pend;
      bus.D_stall  = w_load_use;
      // load/use wins over a pending ret: decode must hold, not be flushed
      bus.D_bubble = w_mispred | (w_ret_pend & ~w_load_use);
      bus.E_bubble = w_mispred | w_load_use;
      // an exception in M or W must not let younger stores reach memory
      bus.M_bubble = ~w_m_ok | ~w_w_ok;
      bus.W_stall  = ~w_w_ok;
      // no CC update when an older instruction is already faulting
      bus.set_cc   = (bus.E_icode == I_OPQ) & w_m_ok & w_w_ok;
    end
  end

  assign bus.cpu_stat    = r_cpu_stat;
  assign bus.halted      = r_halted;
  assign bus.cycle_count = r_cycle_count;
  assign bus.instr_count = r_instr_count;
  assign bus.lu_count    = r_lu_count;
  assign bus.mp_count    = r_mp_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              en);
    if (en && !(&v)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  // Status FSM and counters. The transition cycle itself is still a RUN
  // cycle, so it is counted; the faulting instruction in W is not retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_cpu_stat    <= STAT_AOK;
      r_halted      <= 1'b0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
      r_lu_count    <= '0;
      r_mp_count    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle_count <= sat_inc(r_cycle_count, 1'b1);
          r_instr_count <= sat_inc(r_instr_count, w_retire);
          r_lu_count    <= sat_inc(r_lu_count, w_load_use);
          r_mp_count    <= sat_inc(r_mp_count, w_mispred);
          if (!w_w_ok) begin
            r_state    <= ST_STOPPED;
            r_cpu_stat <= bus.W_stat;
            r_halted   <= 1'b1;
          end
        end
        ST_STOPPED: begin
          r_state <= ST_STOPPED;
        end
        default: begin
          r_state <= ST_STOPPED;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the Y86-64 five-stage pipeline. Generates stall and bubble controls for the F/D/E/M/W pipeline registers and gates the execute stage's condition-code update (set_cc). Holds the processor status state machine (RUN/STOPPED) and the performance counters. Sits beside the stage modules and takes their stage-register and stage-output signals.

Parameters:
CNT_W, 32, width of each performance counter
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
D_icode  input  4  icode in decode register
d_srcA  input  4  decode-stage srcA
d_srcB  input  4  decode-stage srcB
E_icode  input  4  icode in execute register
E_dstM  input  4  execute-register dstM
e_cnd  input  1  execute-stage condition result
M_icode  input  4  icode in memory register
m_stat  input  3  memory-stage status
W_icode  input  4  icode in writeback register
W_stat  input  3  writeback-register status
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold decode register
D_bubble  output  1  load nop into decode register
E_bubble  output  1  load nop into execute register
M_bubble  output  1  load nop into memory register
W_stall  output  1  hold writeback register
set_cc  output  1  permit ZF/SF/OF update this cycle
cpu_stat  output  3  processor status (1 AOK, 2 HLT, 3 ADR, 4 INS)
halted  output  1  high in STOPPED
cycle_count  output  CNT_W  cycles spent in RUN
instr_count  output  CNT_W  non-nop instructions retired
lu_count  output  CNT_W  load/use stall cycles
mp_count  output  CNT_W  mispredicted jumps

Behaviour:
- AOK is 1. A bubble is icode 1 (nop) with status AOK.
- Reset (rst=1 at posedge): state=RUN, cpu_stat=1, halted=0, all counters 0. Reset wins over every other event, including mid-drain.
- Hazard terms (combinational):
  - load_use = (E_icode==5 or 11) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB)
  - ret_pend = D_icode==9 or E_icode==9 or M_icode==9
  - mispred = E_icode==7 and e_cnd==0
- RUN outputs (combinational, same cycle):
  - F_stall = load_use | ret_pend
  - D_stall = load_use
  - D_bubble = mispred | (ret_pend & ~load_use)
  - E_bubble = mispred | load_use
  - M_bubble = (m_stat!=1) | (W_stat!=1)
  - W_stall = (W_stat!=1)
  - set_cc = (E_icode==6) & (m_stat==1) & (W_stat==1)
- D_stall and D_bubble are never both 1. Load/use takes priority over ret: D_stall wins and D_bubble is suppressed.
- mispred and load_use cannot coexist, because E holds a single icode. If they do, E_bubble=1 and D_bubble=1.
- FSM:
  - RUN -> STOPPED at posedge when W_stat!=1. cpu_stat latches W_stat at that edge.
  - STOPPED is absorbing and is left only by rst.
- STOPPED outputs: F_stall=D_stall=W_stall=1, D_bubble=E_bubble=M_bubble=0, set_cc=0, halted=1. Counters freeze.
- cpu_stat updates only on reset and on the RUN->STOPPED edge. It reads 1 throughout RUN.
- Counters (RUN only, registered, saturate at all-ones with no wrap):
  - cycle_count: +1 every RUN cycle, including the transition cycle.
  - instr_count: +1 when W_stat==1 and W_icode!=1. The faulting or halt instruction is not counted.
  - lu_count: +1 per cycle load_use=1.
  - mp_count: +1 per cycle mispred=1. Each mispredict lasts one cycle in E.
- Latency: stall/bubble/set_cc have zero latency (combinational). Status, halted and counters have one-cycle latency.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 in RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_count 0->1 next edge. E_dstM=15 with d_srcA=15 -> no stall.
- Ret: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 for all 3 cycles; with load_use simultaneously, D_bubble=0 and D_stall=1.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1; mp_count +1. Same stimulus with e_cnd=1 -> no bubbles.
- CC gating: E_icode=6 with m_stat=3 -> set_cc=0, M_bubble=1; with m_stat=1 and W_stat=1 -> set_cc=1.
- Halt: W_icode=0, W_stat=2 at edge N -> from N+1: halted=1, cpu_stat=2, F/D/W stall=1, counters frozen, instr_count excludes the halt; rst at a later edge -> cpu_stat=1, all counters 0.
- Saturation: CNT_W=4, run 20 cycles -> cycle_count holds 15.
